tof_delay_calc: RTL and testbench

- Per-channel time-of-flight delay generator for the beamformer.
- Sits directly downstream of the element-coordinate ROM. It drives the ROM address, reads back each element's (x, z) and computes the two-way plane-wave delay for one focal point (xf, zf).
- Streams one delay per channel to the delay/sample-select stage over a valid/ready handshake.
- Units: all coordinates and delays are in sample-spacing units, integer.

---
 rtl/tof_delay_calc.sv | 213 +++++++++++++++++++++
 tb/tb_tof_delay_calc.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tof_delay_calc.sv
// tof_delay_calc: per-channel two-way time-of-flight delay generator.
// Walks the element-coordinate ROM one channel at a time and, for the latched
// focal point (xf, zf), computes delay = zf + floor(sqrt(dx^2 + dz^2)).
// The root comes from a 17-cycle bit-serial restoring square root.
// Each delay leaves over a valid/ready handshake.
// Optional build macro: TOF_CLAMP_EN saturates the delay at MAX_DELAY and
// flags the saturated words on out_clamped.
module tof_delay_calc #(
    parameter int NUM_CHANNELS = 16,
    parameter int ADDR_WIDTH   = $clog2(NUM_CHANNELS),
    parameter int MAX_DELAY    = 4095
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic signed [15:0]    xf,
    input  logic        [15:0]    zf,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic signed [15:0]    rom_x,
    input  logic signed [15:0]    rom_z,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_chan,
    output logic [17:0]           out_delay,
    output logic                  out_clamped,
    output logic                  done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_SQUARE = 3'd2;
    localparam logic [2:0] S_SQRT   = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] LAST_CH = ADDR_WIDTH'(NUM_CHANNELS - 1);
    // The root is 17 bits wide, so the iteration counter runs 16 down to 0.
    localparam logic [4:0] SQRT_LAST_BIT = 5'd16;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] chan_q, chan_d;
    logic signed [15:0]    xf_q, xf_d;
    logic [15:0]           zf_q, zf_d;
    logic signed [16:0]    dx_q, dx_d;
    logic signed [16:0]    dz_q, dz_d;
    logic [33:0]           rad_q, rad_d;
    logic [19:0]           rem_q, rem_d;
    logic [16:0]           root_q, root_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [17:0]           delay_q, delay_d;
    logic                  clamped_q, clamped_d;

    // Squares are taken in 34 bits; both operands are sign-extended so the
    // product of two negatives comes out positive.
    logic signed [33:0]    dx_ext, dz_ext;
    logic [33:0]           dx_sq, dz_sq;

    // One restoring square-root step: bring down the next two radicand bits
    // and try to subtract (4*root + 1).
    logic [19:0]           rem_sh;
    logic [19:0]           trial;
    logic [19:0]           rem_nx;
    logic [16:0]           root_nx;
    logic [17:0]           sum;

    assign dx_ext = {{17{dx_q[16]}}, dx_q};
    assign dz_ext = {{17{dz_q[16]}}, dz_q};
    assign dx_sq  = dx_ext * dx_ext;
    assign dz_sq  = dz_ext * dz_ext;

    // Square-root datapath for the current iteration.
    always_comb begin
        rem_sh  = 20'({rem_q, rad_q[33:32]});
        trial   = {1'b0, root_q, 2'b01};
        if (rem_sh >= trial) begin
            rem_nx  = rem_sh - trial;
            root_nx = {root_q[15:0], 1'b1};
        end else begin
            rem_nx  = rem_sh;
            root_nx = {root_q[15:0], 1'b0};
        end
        // zf < 2^16 and root < 2^17, so this 18-bit sum cannot overflow.
        sum = {2'b00, zf_q} + {1'b0, root_nx};
    end

    // Sweep FSM and datapath next-state logic.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        xf_d      = xf_q;
        zf_d      = zf_q;
        dx_d      = dx_q;
        dz_d      = dz_q;
        rad_d     = rad_q;
        rem_d     = rem_q;
        root_d    = root_q;
        cnt_d     = cnt_q;
        delay_d   = delay_q;
        clamped_d = clamped_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xf_d    = xf;
                    zf_d    = zf;
                    chan_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // The ROM is read only here. dz is formed in 17 bits, so it
                // stays exact while zf <= 32767.
                dx_d    = {rom_x[15], rom_x} - {xf_q[15], xf_q};
                dz_d    = {rom_z[15], rom_z} - {1'b0, zf_q};
                state_d = S_SQUARE;
            end
            S_SQUARE: begin
                rad_d   = dx_sq + dz_sq;
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = SQRT_LAST_BIT;
                state_d = S_SQRT;
            end
            S_SQRT: begin
                rad_d  = {rad_q[31:0], 2'b00};
                rem_d  = rem_nx;
                root_d = root_nx;
                if (cnt_q == 5'd0) begin
                    // Last result bit: capture the delay word for the OUT state.
`ifdef TOF_CLAMP_EN
                    if (sum > 18'(MAX_DELAY)) begin
                        delay_d   = 18'(MAX_DELAY);
                        clamped_d = 1'b1;
                    end else begin
                        delay_d   = sum;
                        clamped_d = 1'b0;
                    end
`else
                    delay_d   = sum;
                    clamped_d = 1'b0;
`endif
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (chan_q == LAST_CH) begin
                        chan_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        chan_d  = chan_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any sweep in progress without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            chan_q    <= '0;
            xf_q      <= '0;
            zf_q      <= '0;
            dx_q      <= '0;
            dz_q      <= '0;
            rad_q     <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            cnt_q     <= '0;
            delay_q   <= '0;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            xf_q      <= xf_d;
            zf_q      <= zf_d;
            dx_q      <= dx_d;
            dz_q      <= dz_d;
            rad_q     <= rad_d;
            rem_q     <= rem_d;
            root_q    <= root_d;
            cnt_q     <= cnt_d;
            delay_q   <= delay_d;
            clamped_q <= clamped_d;
        end
    end

    // Outputs are decoded from registers only, so none of them depends on
    // an input in the same cycle.
    assign rom_addr  = chan_q;
    assign out_chan  = chan_q;
    assign out_valid = (state_q == S_OUT);
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign out_delay = delay_q;
`ifdef TOF_CLAMP_EN
    assign out_clamped = clamped_q;
`else
    assign out_clamped = 1'b0;
`endif

endmodule

// File: tb/tb_tof_delay_calc.sv
// Scoreboard bench for tof_delay_calc.
// The stimulus pushes expected words, computed from the plain delay formula,
// into a queue. An independent monitor pops and compares them on every
// accepted word.
module tb_tof_delay_calc;

    localparam int NCH = 16;

    typedef struct {
        int     chan;
        longint delay;
        bit     clamped;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [15:0] xf;
    logic        [15:0] zf;
    logic [3:0]         rom_addr;
    logic signed [15:0] rom_x, rom_z;
    logic               busy, out_valid, out_chan_dummy;
    logic               out_ready = 1'b0;
    logic [3:0]         out_chan;
    logic [17:0]        out_delay;
    logic               out_clamped, done;

    logic signed [15:0] rom_xa [NCH];
    logic signed [15:0] rom_za [NCH];

    exp_t exp_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   done_cnt  = 0;
    bit   rdy_rand  = 1'b0;

    always #5 clk = ~clk;

    assign rom_x = rom_xa[rom_addr];
    assign rom_z = rom_za[rom_addr];
    assign out_chan_dummy = 1'b0;

    tof_delay_calc #(.NUM_CHANNELS(NCH), .MAX_DELAY(4095)) dut (
        .clk(clk), .rst(rst), .start(start), .xf(xf), .zf(zf),
        .rom_addr(rom_addr), .rom_x(rom_x), .rom_z(rom_z),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_chan(out_chan), .out_delay(out_delay),
        .out_clamped(out_clamped), .done(done)
    );

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic longint isqrt(input longint n);
        longint r;
        r = longint'($sqrt(real'(n)));
        while (r * r > n) r--;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // Reference: delay = zf + floor(sqrt((x-xf)^2 + (z-zf)^2)).
    function automatic exp_t model(input int c, input logic signed [15:0] x, input logic [15:0] z);
        exp_t   e;
        longint dx, dz;
        dx = longint'(rom_xa[c]) - longint'(x);
        dz = longint'(rom_za[c]) - longint'(z);
        e.chan    = c;
        e.delay   = longint'(z) + isqrt(dx * dx + dz * dz);
        e.clamped = 1'b0;
`ifdef TOF_CLAMP_EN
        if (e.delay > 4095) begin
            e.delay   = 4095;
            e.clamped = 1'b1;
        end
`endif
        return e;
    endfunction

    // Consumer back-pressure.
    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Monitor: compares accepted words, checks hold-while-stalled and the done pulse.
    bit          stall_pend = 1'b0;
    bit          last15     = 1'b0;
    logic [3:0]  s_chan;
    logic [17:0] s_delay;
    logic        s_cl;
    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 1'b0;
            last15     = 1'b0;
        end else begin
            if (stall_pend) begin
                check(out_valid && out_chan == s_chan && out_delay == s_delay && out_clamped == s_cl,
                      "stall_hold", longint'(out_delay), longint'(s_delay));
            end
            if (done) begin
                check(last15 && !busy, "done_after_last_accept", {last15, busy}, 2'b10);
                done_cnt++;
            end
            stall_pend = 1'b0;
            last15     = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_word", longint'(out_chan), -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(int'(out_chan) == e.chan, "out_chan", longint'(out_chan), e.chan);
                    check(longint'(out_delay) == e.delay && out_clamped == e.clamped,
                          "out_delay", longint'(out_delay), e.delay);
                end
                last15 = (out_chan == 4'(NCH - 1));
            end else if (out_valid) begin
                stall_pend = 1'b1;
                s_chan     = out_chan;
                s_delay    = out_delay;
                s_cl       = out_clamped;
            end
        end
    end

    task automatic random_rom();
        for (int i = 0; i < NCH; i++) begin
            rom_xa[i] = 16'($urandom);
            rom_za[i] = 16'($urandom);
        end
    endtask

    // Run one sweep; optionally disturb start/xf/zf mid-sweep.
    task automatic sweep(input logic signed [15:0] x, input logic [15:0] z, input bit disturb);
        int n;
        int k;
        int d0;
        d0 = done_cnt;
        for (int c = 0; c < NCH; c++) exp_q.push_back(model(c, x, z));
        @(posedge clk); #1;
        xf = x; zf = z; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(n == 20, "first_valid_latency", n, 20);
        if (disturb) begin
            repeat (45) @(posedge clk);
            #1;
            xf = xf ^ 16'sh1234; zf = zf + 16'd100; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        k = 0;
        while (done_cnt == d0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        check(done_cnt == d0 + 1, "done_count", done_cnt - d0, 1);
        check(exp_q.size() == 0, "all_words_seen", exp_q.size(), 0);
    endtask

    initial begin
        int k;
        int d0;
        rst = 1'b1; start = 1'b0; xf = '0; zf = '0;
        random_rom();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(!out_valid, "rst_out_valid", out_valid, 0);
        check(!busy, "rst_busy", busy, 0);
        check(!done, "rst_done", done, 0);
        check(rom_addr == 0, "rst_rom_addr", rom_addr, 0);
        check(out_delay == 0 && out_chan == 0 && !out_clamped, "rst_data", out_delay, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ch0 (3,0), focus (0,4): 4 + sqrt(25) = 9.
        rom_xa[0] = 16'sd3; rom_za[0] = 16'sd0;
        rdy_rand = 1'b0;
        sweep(16'sd0, 16'd4, 1'b0);

        // ch1 (1,0), focus (0,1): rad 2 -> floor root 1 -> 2.
        rdy_rand = 1'b1;
        random_rom();
        rom_xa[1] = 16'sd1; rom_za[1] = 16'sd0;
        sweep(16'sd0, 16'd1, 1'b0);

        // Coordinate extremes: rad 8589672450, root 92680, delay 125447.
        random_rom();
        rom_xa[0] = 16'sh7fff; rom_za[0] = -16'sh8000;
        sweep(-16'sh8000, 16'd32767, 1'b0);

        // Mid-sweep start and focal changes must be ignored.
        random_rom();
        sweep(16'($urandom), 16'($urandom_range(0, 32767)), 1'b1);

        for (int s = 0; s < 3; s++) begin
            random_rom();
            sweep(16'($urandom), 16'($urandom_range(0, 32767)), 1'b0);
        end

        // Reset during the square root of channel 5.
        rdy_rand = 1'b0;
        random_rom();
        for (int c = 0; c < NCH; c++) exp_q.push_back(model(c, 16'sd100, 16'd200));
        @(posedge clk); #1;
        xf = 16'sd100; zf = 16'd200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        @(negedge clk);
        while (!(rom_addr == 4'd5 && busy && !out_valid) && k < 2000) begin
            k++;
            @(negedge clk);
        end
        check(k < 2000, "reach_ch5", k, 0);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        d0 = done_cnt;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check(!out_valid, "abort_out_valid", out_valid, 0);
        check(!busy, "abort_busy", busy, 0);
        check(rom_addr == 0, "abort_rom_addr", rom_addr, 0);
        repeat (30) @(negedge clk);
        check(done_cnt == d0, "abort_no_done", done_cnt - d0, 0);

        rdy_rand = 1'b1;
        random_rom();
        sweep(16'($urandom), 16'($urandom_range(0, 32767)), 1'b0);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
